mips_multi: RTL

MIPS_MULTI -- requirements
Module: mips_multi

---
 rtl/mips_multi_if.sv | 21 ++
 rtl/mips_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_if.sv
// Shared instruction/data memory port of the multicycle MIPS core.
// The core is the master; the memory (or bench) is the slave.
`timescale 1ns/1ps
interface mips_multi_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_multi.sv
// Multicycle MIPS subset core (lw, sw, add, sub, and, or, slt, addi, beq, j)
// with a single shared memory port and a sticky memory wait timeout flag.
`timescale 1ns/1ps
module mips_multi #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    mips_multi_if.master  bus,
    output logic [31:0]   pc,
    output logic          timeout
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, ALUWB, ADDIEX, BEQ, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    state_t          state;
    logic [31:0]     ir, a, b, aluout, data;
    logic [31:0]     rf [32];
    logic [CW-1:0]   wait_cnt;
    logic            req_q, we_q;
    logic [31:0]     addr_q, wdata_q;

    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd, wb_reg;
    logic [31:0]     imm_se, adr, alu_res, jump_tgt;
    logic            alu_ok;

    always_comb begin
        opcode   = ir[31:26];
        rs       = ir[25:21];
        rt       = ir[20:16];
        rd       = ir[15:11];
        funct    = ir[5:0];
        imm_se   = {{16{ir[15]}}, ir[15:0]};
        adr      = a + imm_se;
        jump_tgt = {pc[31:28], ir[25:0], 2'b00};
        wb_reg   = (opcode == OP_RTYPE) ? rd : rt;
        alu_ok   = 1'b1;
        alu_res  = '0;
        case (funct)
            6'h20:   alu_res = a + b;
            6'h22:   alu_res = a - b;
            6'h24:   alu_res = a & b;
            6'h25:   alu_res = a | b;
            6'h2A:   alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: alu_ok  = 1'b0;
        endcase
    end

    // req_q resets to 1 because state resets to FETCH; gating with reset keeps
    // the bus idle while reset is held and lets the first fetch issue at once.
    assign bus.mem_req   = req_q & ~reset;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            aluout   <= '0;
            data     <= '0;
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= RESET_PC;
            wdata_q  <= '0;
        end else begin
            // Count consecutive stalled cycles; the access itself is never aborted.
            if (req_q) begin
                if (bus.mem_ready) begin
                    wait_cnt <= '0;
                end else begin
                    if (wait_cnt != CW'(WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
                    if (32'(wait_cnt) + 32'd1 >= WAIT_MAX) timeout <= 1'b1;
                end
            end

            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir    <= bus.mem_rdata;
                        pc    <= pc + 32'd4;
                        req_q <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a      <= rf[rs];
                    b      <= rf[rt];
                    aluout <= pc + (imm_se << 2);
                    case (opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_BEQ:       state <= BEQ;
                        OP_J:         state <= JUMP;
                        default: begin
                            state  <= FETCH;
                            req_q  <= 1'b1;
                            addr_q <= pc;
                        end
                    endcase
                end
                MEMADR: begin
                    aluout <= adr;
                    addr_q <= adr;
                    req_q  <= 1'b1;
                    if (opcode == OP_SW) begin
                        we_q    <= 1'b1;
                        wdata_q <= b;
                        state   <= MEMWR;
                    end else begin
                        state   <= MEMRD;
                    end
                end
                MEMRD: begin
                    if (bus.mem_ready) begin
                        data  <= bus.mem_rdata;
                        req_q <= 1'b0;
                        state <= MEMWB;
                    end
                end
                MEMWB: begin
                    if (rt != 5'd0) rf[rt] <= data;
                    state  <= FETCH;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                end
                MEMWR: begin
                    if (bus.mem_ready) begin
                        we_q   <= 1'b0;
                        addr_q <= pc;
                        state  <= FETCH;
                    end
                end
                RTYPEEX: begin
                    if (alu_ok) begin
                        aluout <= alu_res;
                        state  <= ALUWB;
                    end else begin
                        state  <= FETCH;
                        req_q  <= 1'b1;
                        addr_q <= pc;
                    end
                end
                ADDIEX: begin
                    aluout <= adr;
                    state  <= ALUWB;
                end
                ALUWB: begin
                    if (wb_reg != 5'd0) rf[wb_reg] <= aluout;
                    state  <= FETCH;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                end
                BEQ: begin
                    if (a == b) begin
                        pc     <= aluout;
                        addr_q <= aluout;
                    end else begin
                        addr_q <= pc;
                    end
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                JUMP: begin
                    pc     <= jump_tgt;
                    addr_q <= jump_tgt;
                    state  <= FETCH;
                    req_q  <= 1'b1;
                end
                default: begin
                    state  <= FETCH;
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    addr_q <= pc;
                end
            endcase
        end
    end

endmodule
